// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                            |
// | Purpose  : 8N1 UART transmitter fed through a valid/ready byte     |
// |            FIFO. Frames are sent LSB first, CLKS_PER_BIT clocks    |
// |            per bit, with 1 or 2 stop bits.                         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 173,
  parameter int DEPTH_LOG2   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_tx,
  output logic                o_busy,
  output logic [DEPTH_LOG2:0] o_count
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);
  localparam logic [2:0]          c_STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers (one extra bit distinguishes full from empty)
  logic [7:0]          r_mem [c_DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [7:0]          w_head;

  // Serialiser state
  state_t              r_state;
  state_t              w_state_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_next;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_next;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_next;
  logic                r_tx;
  logic                w_tx_next;
  logic                w_bit_end;

  // Ready depends only on pointer registers, never on i_valid
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == '0);
  assign o_ready   = (w_count != c_FULL);
  assign w_push    = i_valid && o_ready;
  assign w_head    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign w_bit_end = (r_cnt == c_CNT_LAST);

  assign o_count = w_count;
  assign o_tx    = r_tx;
  assign o_busy  = (r_state != IDLE) || !w_empty;

  // FIFO storage: written on every accepted byte, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end
  end

  // FIFO pointers advance independently, so push+pop keeps the count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Serialiser registers; the line level is registered from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  // Next-state, baud/bit counting and the line level of the coming cycle
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_next  = 1'b1;
        w_cnt_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_state_next = START;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = DATA;
          w_tx_next      = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = '0;
            w_state_next   = STOP;
            w_tx_next      = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit_idx == c_STOP_LAST) begin
            w_bit_idx_next = '0;
            // Chain straight into the next frame when a byte is waiting
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_shift_next = w_head;
              w_state_next = START;
              w_tx_next    = 1'b0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                         |
// | Purpose  : Scoreboard bench for uart_tx_fifo: a serial receiver    |
// |            decodes frames and checks them against queued bytes.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int CPB = 173;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [4:0] count;

  logic [7:0] data2;
  logic       valid2;
  logic       ready2;
  logic       tx2;
  logic       busy2;
  logic [2:0] count2;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] push_buf[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_count(count)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH_LOG2(2), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data2), .i_valid(valid2),
    .o_ready(ready2), .o_tx(tx2), .o_busy(busy2), .o_count(count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive push_buf into one DUT, one byte per cycle; the first n_acc are expected out
  task automatic push_seq(input int which, input int n_acc);
    foreach (push_buf[i]) begin
      @(negedge clk);
      if (which == 0) begin
        data  = push_buf[i];
        valid = 1'b1;
        if (i < n_acc) exp_q.push_back(push_buf[i]);
      end else begin
        data2  = push_buf[i];
        valid2 = 1'b1;
      end
    end
    @(negedge clk);
    valid  = 1'b0;
    valid2 = 1'b0;
  endtask

  // Compare the line cycle by cycle against ideal frames built from push_buf;
  // launched together with push_seq, the start bit is due on the 3rd negedge
  task automatic wave_check(input string name, input int which, input int cpb,
                            input int stops, input int nframes);
    int   flen, total, bad, bad_n, f, r, idx;
    logic e, a, bad_a, bad_e;
    flen = cpb * (9 + stops);
    total = flen * nframes;
    bad = 0; bad_n = 0; bad_a = 1'b0; bad_e = 1'b0;
    @(negedge clk);
    for (int n = -1; n < total; n++) begin
      @(negedge clk);
      a = (which == 0) ? tx : tx2;
      if (n < 0) begin
        e = 1'b1;
      end else begin
        f   = n / flen;
        r   = n % flen;
        idx = r / cpb;
        if (idx == 0)      e = 1'b0;
        else if (idx <= 8) e = push_buf[f][idx-1];
        else               e = 1'b1;
      end
      if (a !== e) begin
        if (bad == 0) begin
          bad_n = n; bad_a = a; bad_e = e;
        end
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d wrong samples, first at clock %0d got %b expected %b",
               name, bad, bad_n, bad_a, bad_e);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: a mid-bit sampling receiver; every decoded frame is scored
  initial begin : monitor
    int         k, idx;
    logic [7:0] b;
    logic       ok, active;
    logic [7:0] e;
    active = 1'b0; k = 0; b = '0; ok = 1'b1; idx = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1; k = 0; ok = 1'b1; b = '0;
        end
      end else begin
        k++;
        if (k % CPB == CPB / 2) begin
          idx = k / CPB;
          if (idx == 0) begin
            if (tx !== 1'b0) ok = 1'b0;
          end else if (idx <= 8) begin
            b[idx-1] = tx;
          end else begin
            if (tx !== 1'b1) ok = 1'b0;
            active = 1'b0;
            if (exp_q.size() == 0) begin
              check("rx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("rx_framing", {31'd0, ok}, 32'd1);
              check("rx_byte", {24'd0, b}, {24'd0, e});
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int mx, bad;
    rst_n = 1'b0; data = '0; valid = 1'b0; data2 = '0; valid2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_count", {27'd0, count}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0x41: start bit one clock after acceptance, 1730-clock frame
    push_buf = '{8'h41};
    fork
      push_seq(0, 1);
      wave_check("single_wave", 0, CPB, 1, 1);
    join
    check("single_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_busy_drop", {31'd0, busy}, 32'd0);
    check("single_tx_idle", {31'd0, tx}, 32'd1);
    repeat (5) @(negedge clk);

    // Back-to-back "0","x","c" written on consecutive cycles
    push_buf = '{8'h30, 8'h78, 8'h63};
    mx = 0;
    fork
      push_seq(0, 3);
      wave_check("b2b_wave", 0, CPB, 1, 3);
      begin
        repeat (6) begin
          @(negedge clk);
          if (int'(count) > mx) mx = int'(count);
        end
      end
    join
    check("b2b_count_peak", mx, 2);
    wait_idle("b2b_idle", 200);
    repeat (5) @(negedge clk);

    // Push landing on the exact edge where STOP pops the queued byte
    push_buf = '{8'h5A};
    push_seq(0, 1);
    repeat (8) @(negedge clk);
    data = 8'hC3; valid = 1'b1; exp_q.push_back(8'hC3);
    @(negedge clk);
    valid = 1'b0;
    repeat (1721) @(negedge clk);
    check("simul_count_before", {27'd0, count}, 32'd1);
    data = 8'h96; valid = 1'b1; exp_q.push_back(8'h96);
    @(negedge clk);
    valid = 1'b0;
    check("simul_count_after", {27'd0, count}, 32'd1);
    check("simul_new_start", {31'd0, tx}, 32'd0);
    wait_idle("simul_idle", 2 * 1730 + 100);
    repeat (5) @(negedge clk);

    // Fill: 17 accepted (one in the shifter, 16 queued), 18th ignored
    push_buf.delete();
    for (int i = 0; i < 17; i++) push_buf.push_back(8'(8'h10 + i * 7));
    push_seq(0, 17);
    check("full_count", {27'd0, count}, 32'd16);
    check("full_ready", {31'd0, ready}, 32'd0);
    data = 8'hEE; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("full_write_ignored", {27'd0, count}, 32'd16);
    wait_idle("full_idle", 17 * 1730 + 100);
    repeat (5) @(negedge clk);

    // Two stop bits at 4 clocks per bit: 0xFF gives 4 low then 40 high
    push_buf = '{8'hFF};
    fork
      push_seq(1, 0);
      wave_check("s2_ff_wave", 1, 4, 2, 1);
    join
    check("s2_ff_busy_last", {31'd0, busy2}, 32'd1);
    @(negedge clk);
    check("s2_ff_busy_drop", {31'd0, busy2}, 32'd0);
    repeat (3) @(negedge clk);
    push_buf = '{8'hA5, 8'h3C};
    fork
      push_seq(1, 0);
      wave_check("s2_b2b_wave", 1, 4, 2, 2);
    join
    @(negedge clk);
    check("s2_b2b_busy_drop", {31'd0, busy2}, 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-frame with another byte still queued
    push_buf = '{8'h55, 8'hAA};
    push_seq(0, 2);
    repeat (400) @(negedge clk);
    check("rst_pre_low", {31'd0, tx}, 32'd0);
    check("rst_pre_count", {27'd0, count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx}, 32'd1);
    check("rst_async_count", {27'd0, count}, 32'd0);
    check("rst_async_ready", {31'd0, ready}, 32'd1);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rst_no_spurious", bad, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
